// File: rtl/toy_control_unit_if.sv
// Instruction-fetch bus between the toy control unit (master) and instruction memory (slave).
// The master raises imem_req; the slave answers with imem_ack, and imem_data is valid in that same cycle.
interface toy_control_unit_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/toy_control_unit.sv
// Multi-cycle fetch/decode/execute/write-back sequencer for the toy CPU ALU.
// It keeps the zero/carry flag register, and conditional branches read those flags.
module toy_control_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    toy_control_unit_if.master imem,
    output logic [2:0]       alu_op,
    output logic [3:0]       rs_addr,
    output logic [3:0]       rt_addr,
    output logic [3:0]       rd_addr,
    output logic             reg_we,
    input  logic             alu_z,
    input  logic             alu_c,
    output logic             flag_z,
    output logic             flag_c,
    output logic [PC_W-1:0]  pc,
    output logic             halted
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_JZ   = 4'b1000;
    localparam logic [3:0] OP_JC   = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [15:0]     ir_reg, ir_next;
    logic            flag_z_reg, flag_z_next;
    logic            flag_c_reg, flag_c_next;

    logic [3:0]      opcode;
    logic            is_alu;
    logic            is_jz;
    logic            is_jc;
    logic            is_halt;
    logic [PC_W-1:0] target;

    assign opcode = ir_reg[15:12];

    always_comb begin
        is_alu  = 1'b0;
        is_jz   = 1'b0;
        is_jc   = 1'b0;
        is_halt = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_SHL,
            OP_XOR, OP_OR,  OP_AND: is_alu  = 1'b1;
            OP_JZ:                  is_jz   = 1'b1;
            OP_JC:                  is_jc   = 1'b1;
            OP_HALT:                is_halt = 1'b1;
            default:                ;
        endcase
    end

    // Branch target is ir[7:0], zero-extended or truncated to the PC width.
    genvar gi;
    generate
        for (gi = 0; gi < PC_W; gi++) begin : g_target
            if (gi < 8) begin : g_bit
                assign target[gi] = ir_reg[gi];
            end else begin : g_zero
                assign target[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= FETCH;
            pc_reg     <= RESET_PC;
            ir_reg     <= '0;
            flag_z_reg <= 1'b0;
            flag_c_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            flag_z_reg <= flag_z_next;
            flag_c_reg <= flag_c_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        ir_next     = ir_reg;
        flag_z_next = flag_z_reg;
        flag_c_next = flag_c_reg;
        case (state_reg)
            FETCH: begin
                if (imem.imem_ack) begin
                    ir_next    = imem.imem_data;
                    pc_next    = pc_reg + PC_W'(1);
                    state_next = DECODE;
                end
            end
            DECODE: begin
                state_next = is_halt ? HALT : EXECUTE;
            end
            EXECUTE: begin
                // Branches test the flags as they were before this instruction.
                if (is_alu) begin
                    flag_z_next = alu_z;
                    flag_c_next = alu_c;
                    state_next  = WRITEBACK;
                end else begin
                    if ((is_jz && flag_z_reg) || (is_jc && flag_c_reg)) begin
                        pc_next = target;
                    end
                    state_next = FETCH;
                end
            end
            WRITEBACK: state_next = FETCH;
            HALT:      state_next = HALT;
            default:   state_next = FETCH;
        endcase
    end

    // The fetch request is gated by rst_n so that it is low while reset is held.
    // reg_we is decoded from the state register, so asserting reset removes it without waiting for a clock edge.
    assign imem.imem_req  = (state_reg == FETCH) && rst_n;
    assign imem.imem_addr = pc_reg;
    assign reg_we         = (state_reg == WRITEBACK);
    assign halted         = (state_reg == HALT);

    assign alu_op  = is_alu ? opcode[2:0] : 3'b000;
    assign rd_addr = ir_reg[11:8];
    assign rs_addr = ir_reg[7:4];
    assign rt_addr = ir_reg[3:0];

    assign pc     = pc_reg;
    assign flag_z = flag_z_reg;
    assign flag_c = flag_c_reg;

endmodule

// File: tb/tb_toy_control_unit.sv
// Directed bench for toy_control_unit: a program of ALU, branch, NOP and HALT instructions,
// plus resets applied mid-instruction; every expected value is worked out by hand.
module tb_toy_control_unit;

    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      alu_op;
    logic [3:0]      rs_addr, rt_addr, rd_addr;
    logic            reg_we;
    logic            alu_z, alu_c;
    logic            flag_z, flag_c;
    logic [PC_W-1:0] pc;
    logic            halted;

    int n_checks  = 0;
    int n_fail    = 0;
    int we_pulses = 0;
    int exp_we    = 0;

    always #5 clk = ~clk;

    toy_control_unit_if #(.PC_W(PC_W)) imem_bus ();

    toy_control_unit #(
        .PC_W     (PC_W),
        .RESET_PC (8'h00)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .imem    (imem_bus),
        .alu_op  (alu_op),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rd_addr (rd_addr),
        .reg_we  (reg_we),
        .alu_z   (alu_z),
        .alu_c   (alu_c),
        .flag_z  (flag_z),
        .flag_c  (flag_c),
        .pc      (pc),
        .halted  (halted)
    );

    // Counts write-enable pulses; each WRITEBACK cycle contains exactly one falling edge.
    always @(negedge clk) begin
        if (reg_we === 1'b1) we_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called in FETCH: present one instruction with ack; returns one step into DECODE.
    task automatic do_fetch(input logic [15:0] instr, input logic [7:0] addr);
        $display("txn fetch addr=%02h instr=%04h", addr, instr);
        check("fetch_req", imem_bus.imem_req, 1'b1);
        check("fetch_addr", imem_bus.imem_addr, addr);
        imem_bus.imem_ack  = 1'b1;
        imem_bus.imem_data = instr;
        tick();
        imem_bus.imem_ack  = 1'b0;
        imem_bus.imem_data = 16'h0000;
    endtask

    task automatic run_alu(input logic [15:0] instr, input logic [7:0] addr,
                           input logic z, input logic c, input logic [2:0] op);
        logic [7:0] next_pc;
        next_pc = addr + 8'd1;
        do_fetch(instr, addr);
        check("dec_alu_op", alu_op, op);
        check("dec_rd", rd_addr, instr[11:8]);
        check("dec_rs", rs_addr, instr[7:4]);
        check("dec_rt", rt_addr, instr[3:0]);
        check("dec_pc", pc, next_pc);
        alu_z = z;
        alu_c = c;
        tick();
        check("exe_reg_we", reg_we, 1'b0);
        tick();
        check("wb_reg_we", reg_we, 1'b1);
        check("wb_flag_z", flag_z, z);
        check("wb_flag_c", flag_c, c);
        alu_z = ~z;
        alu_c = ~c;
        tick();
        exp_we++;
        check("alu_we_count", we_pulses, exp_we);
        check("alu_back_fetch", imem_bus.imem_req, 1'b1);
    endtask

    // Branches and NOPs: three cycles including the fetch, no reg_we.
    task automatic run_branch(input logic [15:0] instr, input logic [7:0] addr,
                              input logic [7:0] exp_pc);
        logic [7:0] next_pc;
        next_pc = addr + 8'd1;
        do_fetch(instr, addr);
        check("br_dec_pc", pc, next_pc);
        alu_z = 1'b1;
        alu_c = 1'b0;
        tick();
        tick();
        check("br_pc", pc, exp_pc);
        check("br_addr", imem_bus.imem_addr, exp_pc);
        check("br_req", imem_bus.imem_req, 1'b1);
        check("br_we_count", we_pulses, exp_we);
    endtask

    initial begin
        rst_n              = 1'b1;
        alu_z              = 1'b0;
        alu_c              = 1'b0;
        imem_bus.imem_ack  = 1'b0;
        imem_bus.imem_data = 16'h0000;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 8'h00);
        check("rst_req", imem_bus.imem_req, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_reg_we", reg_we, 1'b0);
        check("rst_alu_op", alu_op, 3'b000);
        check("rst_rd", rd_addr, 4'h0);
        check("rst_rs", rs_addr, 4'h0);
        check("rst_rt", rt_addr, 4'h0);
        check("rst_flag_z", flag_z, 1'b0);
        check("rst_flag_c", flag_c, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // ADD r1,r2,r3 with ack in the first fetch cycle.
        run_alu(16'h0123, 8'h00, 1'b0, 1'b0, 3'b000);

        // Ack held off for five cycles.
        for (int i = 0; i < 5; i++) begin
            check("wait_req", imem_bus.imem_req, 1'b1);
            check("wait_pc", pc, 8'h01);
            tick();
        end
        check("wait_we_count", we_pulses, exp_we);

        // SUB sets Z, so JZ 0x40 is taken.
        run_alu(16'h1456, 8'h01, 1'b1, 1'b0, 3'b001);
        run_branch(16'h8040, 8'h02, 8'h40);
        check("jz_flag_z_kept", flag_z, 1'b1);

        // SUB clears Z and sets C, so JZ falls through to the next address.
        run_alu(16'h1789, 8'h40, 1'b0, 1'b1, 3'b001);
        run_branch(16'h8040, 8'h41, 8'h42);

        // JC to 0xFF, then a fetch at 0xFF wraps pc to 0x00 before JC 0x10 is taken.
        run_branch(16'h90FF, 8'h42, 8'hFF);
        run_branch(16'h9010, 8'hFF, 8'h10);

        // Undefined opcode: acts as a NOP and leaves the flags alone even though the ALU outputs toggle.
        run_branch(16'h2ABC, 8'h10, 8'h11);
        check("nop_flag_z", flag_z, 1'b0);
        check("nop_flag_c", flag_c, 1'b1);

        // A logic op clears C, so JC is not taken.
        run_alu(16'h7123, 8'h11, 1'b0, 1'b0, 3'b111);
        run_branch(16'h9030, 8'h12, 8'h13);
        run_alu(16'h5123, 8'h13, 1'b1, 1'b1, 3'b101);

        // Reset asserted in the middle of WRITEBACK.
        do_fetch(16'h0321, 8'h14);
        alu_z = 1'b1;
        alu_c = 1'b0;
        tick();
        tick();
        check("wb_before_rst", reg_we, 1'b1);
        check("flag_z_before_rst", flag_z, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reg_we", reg_we, 1'b0);
        check("async_pc", pc, 8'h00);
        check("async_flag_z", flag_z, 1'b0);
        check("async_flag_c", flag_c, 1'b0);
        check("async_req", imem_bus.imem_req, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_we_count", we_pulses, exp_we);
        check("post_rst_req", imem_bus.imem_req, 1'b1);
        check("post_rst_addr", imem_bus.imem_addr, 8'h00);

        // HALT; acks presented while halted must be ignored.
        do_fetch(16'hF000, 8'h00);
        tick();
        imem_bus.imem_ack  = 1'b1;
        imem_bus.imem_data = 16'h0123;
        for (int i = 0; i < 20; i++) begin
            check("halt_halted", halted, 1'b1);
            check("halt_req", imem_bus.imem_req, 1'b0);
            check("halt_pc", pc, 8'h01);
            tick();
        end
        imem_bus.imem_ack  = 1'b0;
        imem_bus.imem_data = 16'h0000;
        check("halt_we_count", we_pulses, exp_we);
        rst_n = 1'b0;
        #1;
        check("halt_rst_pc", pc, 8'h00);
        check("halt_rst_halted", halted, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("halt_exit_req", imem_bus.imem_req, 1'b1);
        check("halt_exit_addr", imem_bus.imem_addr, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/toy_control_unit.md
Name: toy_control_unit

Overview:
- Multi-cycle fetch/decode/sequencing stage directly upstream of the toy CPU ALU.
- Fetches 16-bit instructions over a req/ack handshake, decodes them into the ALU's 3-bit operation code and register-file addresses, and sequences register write-back.
- Latches the ALU zero/carry outputs into a flag register and uses it for conditional branches.

Parameters:
- PC_W, 8, program counter width (instruction address space 2^PC_W words).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (equals pc).
- imem_ack  in  1  fetch complete; imem_data is valid in the same cycle.
- imem_data  in  16  instruction word.
- alu_op  out  3  operation code to ALU.
- rs_addr  out  4  register-file read address for ALU operand a.
- rt_addr  out  4  register-file read address for ALU operand src.
- rd_addr  out  4  register-file write address.
- reg_we  out  1  register-file write enable, one cycle pulse.
- alu_z  in  1  ALU zero output.
- alu_c  in  1  ALU carry output.
- flag_z  out  1  latched zero flag.
- flag_c  out  1  latched carry flag.
- pc  out  PC_W  program counter.
- halted  out  1  high while in HALT.

Behaviour:
- Instruction format: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt; branch target = [7:0], zero-extended or truncated to PC_W.
- Opcode decode:
  - 0000 ADD → alu_op 000.
  - 0001 SUB → 001.
  - 0100 SHL → 100.
  - 0101 XOR → 101.
  - 0110 OR → 110.
  - 0111 AND → 111.
  - 1000 JZ.
  - 1001 JC.
  - 1111 HALT.
  - All other opcodes: NOP (no write, no flag update).
- Reset (async, rst_n low): state=FETCH, pc=RESET_PC, ir=0, flag_z=0, flag_c=0, reg_we=0, imem_req=0, halted=0, alu_op=000, all address outputs 0.
- FSM states: FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - Stays in FETCH until imem_ack=1.
  - On ack: ir<=imem_data, pc<=pc+1 (wraps modulo 2^PC_W), go to DECODE.
- DECODE:
  - Drives rs_addr, rt_addr, rd_addr and alu_op from ir; these hold stable through EXECUTE and WRITEBACK.
  - Next state: HALT opcode → HALT; otherwise EXECUTE.
- EXECUTE:
  - ALU opcodes: sample alu_z/alu_c at the end of the cycle into flag_z/flag_c, then go to WRITEBACK.
  - JZ: if flag_z=1, pc<=target; go to FETCH.
  - JC: if flag_c=1, pc<=target; go to FETCH.
  - Branches use the flags as they stand before this instruction.
  - NOP: go to FETCH.
- WRITEBACK: reg_we=1 for exactly this cycle, then go to FETCH. reg_we is 0 in all other states.
- HALT: halted=1, imem_req=0. The only exit is reset.
- Cycle counts: ALU instruction = fetch-wait + 4 cycles. Branch and NOP = fetch-wait + 3 cycles. Minimum fetch-wait is 1 cycle (ack in the first FETCH cycle).
- imem_ack outside FETCH is ignored.
- Reset asserted mid-instruction aborts it immediately. No reg_we pulse may follow reset deassertion until a new WRITEBACK.
- Flags change only in EXECUTE of ALU opcodes. SUB and logic ops also update flag_c from alu_c.

Test Plan:
- Reset then ack immediately with 0x0123 (ADD r1,r2,r3) → imem_addr=0; alu_op=000, rs=2, rt=3, rd=1 from DECODE; reg_we pulses exactly once, 4 cycles after ack; pc=1.
- Hold imem_ack low for 5 cycles → imem_req stays high, state stays FETCH, pc unchanged, no reg_we.
- ALU drives z=1,c=0 during SUB EXECUTE, then fetch 0x8040 (JZ 0x40) → flag_z=1, pc=0x40 at the next FETCH. Repeat with z=0 → pc continues sequentially.
- JC 0x10 with flag_c=1 and PC_W=8 at pc=0xFF → fetch at 0xFF increments pc to 0x00, then branch sets pc=0x10.
- Fetch 0xF000 → halted=1, imem_req=0 for 20 cycles. Assert rst_n low → pc=RESET_PC, halted=0.
- Assert rst_n low during WRITEBACK → reg_we drops asynchronously. After release: FETCH at RESET_PC, flags 0.
- Undefined opcode 0x2xxx → no reg_we, flags unchanged, returns to FETCH after 3 cycles.
